serial_magnitude_comparator: RTL and testbench



---
 rtl/serial_magnitude_comparator.sv | 110 +++++++++++
 tb/tb_serial_magnitude_comparator.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial, MSB-first unsigned magnitude comparator.
// An operand pair is taken over a valid/ready handshake. The bits are then
// walked one per clock, and the walk stops at the first differing bit.
// A one-hot gt/lt/eq result is returned over a second valid/ready handshake.
module serial_magnitude_comparator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             a_gt_b,
   output logic             a_lt_b,
   output logic             a_eq_b,
   output logic             busy
);

   // Counter holds the index of the bit currently at the MSB of the shifters.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] a_sh_reg;
   logic [WIDTH-1:0] b_sh_reg;
   logic [CW-1:0]    cnt_reg;
   logic             gt_reg;
   logic             lt_reg;
   logic             eq_reg;

   logic a_msb;
   logic b_msb;

   assign a_msb = a_sh_reg[WIDTH-1];
   assign b_msb = b_sh_reg[WIDTH-1];

   // Control FSM. It also handles the operand shifters and the result flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_sh_reg  <= '0;
         b_sh_reg  <= '0;
         cnt_reg   <= '0;
         gt_reg    <= 1'b0;
         lt_reg    <= 1'b0;
         eq_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               // in_ready is high in IDLE whenever reset is released,
               // so in_valid alone qualifies the accept.
               if (in_valid) begin
                  a_sh_reg  <= a;
                  b_sh_reg  <= b;
                  cnt_reg   <= CW'(WIDTH - 1);
                  state_reg <= SHIFT;
               end
            end
            SHIFT: begin
               if (a_msb != b_msb) begin
                  // The first differing bit decides the result.
                  gt_reg    <= a_msb;
                  lt_reg    <= b_msb;
                  eq_reg    <= 1'b0;
                  state_reg <= DONE;
               end else if (cnt_reg == '0) begin
                  gt_reg    <= 1'b0;
                  lt_reg    <= 1'b0;
                  eq_reg    <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  a_sh_reg <= a_sh_reg << 1;
                  b_sh_reg <= b_sh_reg << 1;
                  cnt_reg  <= cnt_reg - CW'(1);
               end
            end
            DONE: begin
               // Clear the flags so that they read 0 whenever out_valid is low.
               if (out_ready) begin
                  gt_reg    <= 1'b0;
                  lt_reg    <= 1'b0;
                  eq_reg    <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Handshake and status outputs are decoded from the state only.
   // in_ready is also held low while reset is asserted.
   assign in_ready  = (state_reg == IDLE) && rst_n;
   assign busy      = (state_reg == SHIFT);
   assign out_valid = (state_reg == DONE);
   assign a_gt_b    = gt_reg;
   assign a_lt_b    = lt_reg;
   assign a_eq_b    = eq_reg;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed and randomized bench for serial_magnitude_comparator.
// It covers WIDTH = 8, 1 and 13.
module tb_serial_magnitude_comparator;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // WIDTH = 8 instance
   logic       iv8, ir8, ov8, or8, gt8, lt8, eq8, busy8;
   logic [7:0] a8, b8;
   // WIDTH = 1 instance
   logic       iv1, ir1, ov1, or1, gt1, lt1, eq1, busy1;
   logic [0:0] a1, b1;
   // WIDTH = 13 instance
   logic        iv13, ir13, ov13, or13, gt13, lt13, eq13, busy13;
   logic [12:0] a13, b13;

   serial_magnitude_comparator #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .out_valid(ov8), .out_ready(or8), .a_gt_b(gt8), .a_lt_b(lt8), .a_eq_b(eq8),
      .busy(busy8));

   serial_magnitude_comparator #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
      .out_valid(ov1), .out_ready(or1), .a_gt_b(gt1), .a_lt_b(lt1), .a_eq_b(eq1),
      .busy(busy1));

   serial_magnitude_comparator #(.WIDTH(13)) dut13 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv13), .in_ready(ir13), .a(a13), .b(b13),
      .out_valid(ov13), .out_ready(or13), .a_gt_b(gt13), .a_lt_b(lt13), .a_eq_b(eq13),
      .busy(busy13));

   // Drives the input side of the instance selected by w.
   task automatic set_in(input int w, input logic v, input logic [15:0] av, input logic [15:0] bv);
      case (w)
         1:       begin iv1  = v; a1  = av[0:0];  b1  = bv[0:0];  end
         13:      begin iv13 = v; a13 = av[12:0]; b13 = bv[12:0]; end
         default: begin iv8  = v; a8  = av[7:0];  b8  = bv[7:0];  end
      endcase
   endtask

   function automatic logic get_ov(input int w);
      case (w)
         1:       return ov1;
         13:      return ov13;
         default: return ov8;
      endcase
   endfunction

   function automatic logic get_ir(input int w);
      case (w)
         1:       return ir1;
         13:      return ir13;
         default: return ir8;
      endcase
   endfunction

   function automatic logic get_busy(input int w);
      case (w)
         1:       return busy1;
         13:      return busy13;
         default: return busy8;
      endcase
   endfunction

   function automatic logic [2:0] get_flags(input int w);
      case (w)
         1:       return {gt1, lt1, eq1};
         13:      return {gt13, lt13, eq13};
         default: return {gt8, lt8, eq8};
      endcase
   endfunction

   // Runs one full transaction with out_ready high.
   // It is entered and left at posedge+1 with the instance in IDLE.
   task automatic run_pair(input int w, input logic [15:0] av_in, input logic [15:0] bv_in,
                           input string name);
      logic [15:0] mask, av, bv, diff;
      logic [2:0]  exp_flags;
      int          exp_n, hi, k;
      mask = (16'h1 << w) - 16'h1;
      av   = av_in & mask;
      bv   = bv_in & mask;
      diff = av ^ bv;
      hi   = -1;
      for (int j = 0; j < w; j++) if (diff[j]) hi = j;
      exp_n     = (hi < 0) ? w : (w - hi);
      exp_flags = (av > bv) ? 3'b100 : ((av < bv) ? 3'b010 : 3'b001);

      checks++;
      if (get_ir(w) !== 1'b1 || get_busy(w) !== 1'b0) begin
         errors++;
         $display("FAIL %s idle: in_ready=%b busy=%b, required in_ready=1 busy=0",
                  name, get_ir(w), get_busy(w));
      end
      set_in(w, 1'b1, av, bv);
      @(posedge clk); #1;
      // Scrambled operands after the accept edge must be ignored.
      set_in(w, 1'b0, ~av, ~bv);
      k = 1;
      while (get_ov(w) !== 1'b1 && k < 40) begin
         checks++;
         if (get_busy(w) !== 1'b1 || get_ir(w) !== 1'b0) begin
            errors++;
            $display("FAIL %s shift cycle %0d: busy=%b in_ready=%b, required busy=1 in_ready=0",
                     name, k, get_busy(w), get_ir(w));
         end
         @(posedge clk); #1;
         k++;
      end
      checks++;
      if (k !== exp_n + 1) begin
         errors++;
         $display("FAIL %s latency: a=%h b=%h out_valid cycle=%0d, required %0d",
                  name, av, bv, k, exp_n + 1);
      end
      checks++;
      if (get_flags(w) !== exp_flags || get_busy(w) !== 1'b0) begin
         errors++;
         $display("FAIL %s flags: a=%h b=%h gt/lt/eq=%b busy=%b, required %b busy=0",
                  name, av, bv, get_flags(w), get_busy(w), exp_flags);
      end
      @(posedge clk); #1;
      checks++;
      if (get_ir(w) !== 1'b1 || get_ov(w) !== 1'b0 || get_flags(w) !== 3'b000) begin
         errors++;
         $display("FAIL %s after handshake: in_ready=%b out_valid=%b flags=%b, required 1 0 000",
                  name, get_ir(w), get_ov(w), get_flags(w));
      end
      $display("%s: W=%0d a=%h b=%h flags=%b latency=%0d", name, w, av, bv, exp_flags, exp_n + 1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_in(8, 1'b0, 16'h0, 16'h0);
      set_in(1, 1'b0, 16'h0, 16'h0);
      set_in(13, 1'b0, 16'h0, 16'h0);
      or8 = 1'b1; or1 = 1'b1; or13 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({ir8, ov8, gt8, lt8, eq8, busy8} !== 6'b0) begin
         errors++;
         $display("FAIL reset outputs: ir/ov/gt/lt/eq/busy=%b, required 000000",
                  {ir8, ov8, gt8, lt8, eq8, busy8});
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (ir8 !== 1'b1 || ir1 !== 1'b1 || ir13 !== 1'b1) begin
         errors++;
         $display("FAIL reset release in_ready: %b%b%b, required 111", ir8, ir1, ir13);
      end
      @(posedge clk); #1;
      $display("test_reset done");
   endtask

   task automatic test_basic();
      run_pair(8, 16'h80, 16'h7F, "msb_diff");
      run_pair(8, 16'h05, 16'h06, "bit1_diff");
      run_pair(8, 16'hA5, 16'hA5, "eq_a5");
      run_pair(8, 16'h00, 16'h00, "eq_00");
      run_pair(8, 16'hFF, 16'hFF, "eq_ff");
      run_pair(8, 16'h01, 16'h00, "lsb_diff");
   endtask

   task automatic test_backpressure();
      int k;
      or8 = 1'b0;
      iv8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
      @(posedge clk); #1;
      // in_valid stays high with new operands; they must not be captured.
      a8 = 8'h00; b8 = 8'hFF;
      k = 1;
      while (ov8 !== 1'b1 && k < 40) begin
         checks++;
         if (ir8 !== 1'b0) begin
            errors++;
            $display("FAIL bp shift in_ready: %b, required 0", ir8);
         end
         @(posedge clk); #1;
         k++;
      end
      checks++;
      if (k !== 5) begin
         errors++;
         $display("FAIL bp latency: out_valid cycle=%0d, required 5", k);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (ov8 !== 1'b1 || {gt8, lt8, eq8} !== 3'b100 || ir8 !== 1'b0) begin
            errors++;
            $display("FAIL bp hold %0d: ov=%b flags=%b ir=%b, required ov=1 flags=100 ir=0",
                     i, ov8, {gt8, lt8, eq8}, ir8);
         end
         @(posedge clk); #1;
      end
      or8 = 1'b1;
      iv8 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1 || {gt8, lt8, eq8} !== 3'b000 || busy8 !== 1'b0) begin
         errors++;
         $display("FAIL bp release: ov=%b ir=%b flags=%b busy=%b, required 0 1 000 0",
                  ov8, ir8, {gt8, lt8, eq8}, busy8);
      end
      @(posedge clk); #1;
      checks++;
      if (busy8 !== 1'b0 || ov8 !== 1'b0) begin
         errors++;
         $display("FAIL bp idle stays idle: busy=%b ov=%b, required 0 0", busy8, ov8);
      end
      $display("test_backpressure: a=10 b=01 held 5 cycles");
   endtask

   task automatic test_midreset();
      // Reset in the third SHIFT cycle. 0x00 vs 0x01 keeps SHIFT busy for 8 cycles.
      iv8 = 1'b1; a8 = 8'h00; b8 = 8'h01;
      @(posedge clk); #1;
      iv8 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy8 !== 1'b1) begin
         errors++;
         $display("FAIL midreset pre: busy=%b, required 1", busy8);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({ir8, ov8, gt8, lt8, eq8, busy8} !== 6'b0) begin
         errors++;
         $display("FAIL midreset shift outputs: %b, required 000000",
                  {ir8, ov8, gt8, lt8, eq8, busy8});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ov8 !== 1'b0 || busy8 !== 1'b0 || ir8 !== 1'b1) begin
         errors++;
         $display("FAIL midreset stale: ov=%b busy=%b ir=%b, required 0 0 1", ov8, busy8, ir8);
      end
      run_pair(8, 16'h03, 16'h03, "post_reset_eq");
      // Reset while a result sits in DONE under back-pressure.
      or8 = 1'b0;
      iv8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
      @(posedge clk); #1;
      iv8 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ov8 !== 1'b1 || {gt8, lt8, eq8} !== 3'b010) begin
         errors++;
         $display("FAIL done pre-reset: ov=%b flags=%b, required 1 010", ov8, {gt8, lt8, eq8});
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({ir8, ov8, gt8, lt8, eq8, busy8} !== 6'b0) begin
         errors++;
         $display("FAIL midreset done outputs: %b, required 000000",
                  {ir8, ov8, gt8, lt8, eq8, busy8});
      end
      rst_n = 1'b1;
      or8   = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
         errors++;
         $display("FAIL done reset stale: ov=%b ir=%b, required 0 1", ov8, ir8);
      end
      $display("test_midreset done");
   endtask

   task automatic test_width1();
      run_pair(1, 16'h0, 16'h0, "w1_00");
      run_pair(1, 16'h0, 16'h1, "w1_01");
      run_pair(1, 16'h1, 16'h0, "w1_10");
      run_pair(1, 16'h1, 16'h1, "w1_11");
   endtask

   task automatic test_random(input int w);
      logic [15:0] av, bv;
      for (int i = 0; i < 1000; i++) begin
         av = 16'($urandom);
         bv = ($urandom_range(0, 7) == 0) ? av : 16'($urandom);
         run_pair(w, av, bv, "rand");
      end
   endtask

   task automatic test_back_to_back();
      run_pair(8, 16'h40, 16'h20, "b2b_0");
      run_pair(8, 16'h20, 16'h40, "b2b_1");
      run_pair(8, 16'h3C, 16'h3C, "b2b_2");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_midreset();
      test_width1();
      test_back_to_back();
      test_random(8);
      test_random(13);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
